// File: rtl/frame_uart_sender.sv
// Streams a captured frame from the frame-buffer RAM out over an 8N1 UART, one pixel per byte.
// Define FRAME_UART_SENDER_HEADER_EN to prefix each frame with the sync bytes 0xA5, 0x5A.
module frame_uart_sender #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_PIXELS = 9216,
    parameter int RAM_LATENCY  = 1
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Start,
    output logic [14:0] o_RAM_Adress,
    output logic        o_RAM_Read_Enable,
    input  logic [7:0]  i_RAM_Data,
    output logic        o_Tx,
    output logic        o_Busy,
    output logic        o_Done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_HEADER = 3'd5;

    localparam logic [15:0] BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] FETCH_LAST = 16'(RAM_LATENCY);
    localparam logic [14:0] LAST_PIX   = 15'(FRAME_PIXELS - 1);

    logic [2:0]  state_q,   state_d;
    logic [14:0] pix_q,     pix_d;
    logic [14:0] addr_q,    addr_d;
    logic        rd_en_q,   rd_en_d;
    logic [7:0]  shift_q,   shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] baud_q,    baud_d;
    logic        tx_q,      tx_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;

`ifdef FRAME_UART_SENDER_HEADER_EN
    localparam logic [1:0] HDR_NONE = 2'd0;
    localparam logic [1:0] HDR_A5   = 2'd1;
    localparam logic [1:0] HDR_5A   = 2'd2;
    logic [1:0] hdr_q, hdr_d;
`endif

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d   = state_q;
        pix_d     = pix_q;
        addr_d    = addr_q;
        rd_en_d   = rd_en_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef FRAME_UART_SENDER_HEADER_EN
        hdr_d     = hdr_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                rd_en_d = 1'b0;
                if (i_Start) begin
                    pix_d  = '0;
                    addr_d = '0;
                    busy_d = 1'b1;
                    baud_d = '0;
`ifdef FRAME_UART_SENDER_HEADER_EN
                    hdr_d   = HDR_A5;
                    shift_d = 8'hA5;
                    tx_d    = 1'b0;
                    state_d = S_HEADER;
`else
                    rd_en_d = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end

            // Address has been stable since entry; the final cycle carries valid RAM data.
            S_FETCH: begin
                if (baud_q == FETCH_LAST) begin
                    shift_d = i_RAM_Data;
                    rd_en_d = 1'b0;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = S_START;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            // HEADER is a start bit whose byte came from a constant instead of RAM.
            S_START, S_HEADER: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
`ifdef FRAME_UART_SENDER_HEADER_EN
                    if (hdr_q == HDR_A5) begin
                        hdr_d   = HDR_5A;
                        shift_d = 8'h5A;
                        tx_d    = 1'b0;
                        state_d = S_HEADER;
                    end else if (hdr_q == HDR_5A) begin
                        hdr_d   = HDR_NONE;
                        rd_en_d = 1'b1;
                        state_d = S_FETCH;
                    end else
`endif
                    if (pix_q == LAST_PIX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        pix_d   = pix_q + 15'd1;
                        addr_d  = pix_q + 15'd1;
                        rd_en_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            pix_q     <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef FRAME_UART_SENDER_HEADER_EN
            hdr_q     <= HDR_NONE;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            pix_q     <= pix_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef FRAME_UART_SENDER_HEADER_EN
            hdr_q     <= hdr_d;
`endif
        end
    end

    assign o_RAM_Adress      = addr_q;
    assign o_RAM_Read_Enable = rd_en_q;
    assign o_Tx              = tx_q;
    assign o_Busy            = busy_q;
    assign o_Done            = done_q;

endmodule

// File: tb/tb_frame_uart_sender.sv
// Directed bench for frame_uart_sender: a 1-cycle-latency instance (4 pixels) and a
// 3-cycle-latency instance (2 pixels), both at 4 clocks per UART bit.
module tb_frame_uart_sender;

    localparam int CPB = 4;
`ifdef FRAME_UART_SENDER_HEADER_EN
    localparam int HDR_BYTES = 2;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int HDR_CYC = HDR_BYTES * 10 * CPB;
    localparam int F0_CYC  = 4 * (1 + 1 + 10 * CPB);   // 168
    localparam int F1_CYC  = 2 * (3 + 1 + 10 * CPB);   // 88

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [1:0]  tx, busy, done, rd_en;
    logic [14:0] addr0, addr1;
    logic [7:0]  rdata0, rdata1;

    always #5 clk = ~clk;

    frame_uart_sender #(.CLKS_PER_BIT(CPB), .FRAME_PIXELS(4), .RAM_LATENCY(1)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start[0]),
        .o_RAM_Adress(addr0), .o_RAM_Read_Enable(rd_en[0]), .i_RAM_Data(rdata0),
        .o_Tx(tx[0]), .o_Busy(busy[0]), .o_Done(done[0])
    );

    frame_uart_sender #(.CLKS_PER_BIT(CPB), .FRAME_PIXELS(2), .RAM_LATENCY(3)) dut_lat3 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start[1]),
        .o_RAM_Adress(addr1), .o_RAM_Read_Enable(rd_en[1]), .i_RAM_Data(rdata1),
        .o_Tx(tx[1]), .o_Busy(busy[1]), .o_Done(done[1])
    );

    // BRAM models: one and three register stages after the address.
    logic [7:0] ram0 [4] = '{8'h00, 8'hFF, 8'h55, 8'h81};
    logic [7:0] ram1 [2] = '{8'h01, 8'hC3};
    logic [7:0] pipe1 [3];

    always @(posedge clk) begin
        rdata0   <= ram0[addr0[1:0]];
        pipe1[0] <= ram1[addr1[0]];
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign rdata1 = pipe1[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor, sampled on the falling edge.
    int busy_start [2] = '{0, 0};
    int first_rd_at[2] = '{0, 0};
    int done_at    [2] = '{0, 0};
    int done_cnt   [2] = '{0, 0};
    int rd_cnt     [2] = '{0, 0};
    int addr_cnt   [16];
    bit busy_prev  [2] = '{1'b0, 1'b0};
    bit rd_armed   [2] = '{1'b0, 1'b0};
    bit busy_at_done[2] = '{1'b0, 1'b0};

    initial for (int a = 0; a < 16; a++) addr_cnt[a] = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            busy_prev[i] <= busy[i];
            if (busy[i] && !busy_prev[i]) begin
                busy_start[i] <= cyc;
                if (rd_en[i]) first_rd_at[i] <= cyc;
                rd_armed[i] <= !rd_en[i];
            end else if (rd_armed[i] && rd_en[i]) begin
                first_rd_at[i] <= cyc;
                rd_armed[i]    <= 1'b0;
            end
            if (rd_en[i]) rd_cnt[i] <= rd_cnt[i] + 1;
            if (done[i]) begin
                done_cnt[i]     <= done_cnt[i] + 1;
                done_at[i]      <= cyc;
                busy_at_done[i] <= busy[i];
            end
        end
        if (rd_en[0]) addr_cnt[addr0[3:0]] <= addr_cnt[addr0[3:0]] + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    // Returns once the last stop-bit cycle has been sampled.
    task automatic recv_byte(input int i, output logic [7:0] b, output logic [9:0] bits);
        int t;
        logic v;
        b    = '0;
        bits = '0;
        t    = 0;
        @(negedge clk);
        while (tx[i] !== 1'b0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            check("rx_start_seen", 32'd0, 32'd1);
            return;
        end
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            v = tx[i];
            for (int j = 1; j < CPB; j++) begin
                @(negedge clk);
                check($sformatf("bit_width_b%0d", k), 32'(tx[i]), 32'(v));
            end
            bits[k] = v;
        end
        check("start_bit", 32'(bits[0]), 32'd0);
        check("stop_bit", 32'(bits[9]), 32'd1);
        b = bits[8:1];
    endtask

    task automatic rx_expect(input int i, input logic [7:0] exp[$], input string name);
        logic [7:0] b;
        logic [9:0] bits;
        for (int k = 0; k < exp.size(); k++) begin
            recv_byte(i, b, bits);
            check($sformatf("%s_byte%0d", name, k), 32'(b), 32'(exp[k]));
        end
    endtask

    task automatic wait_done(input int i);
        int t;
        t = 0;
        @(negedge clk);
        while (done[i] !== 1'b1 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 32'(done[i]), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp0[$];
        logic [7:0] exp1[$];
        logic [7:0] b;
        logic [9:0] bits;
        int dc, rc, t, lows, busys;
        int ac[4];

`ifdef FRAME_UART_SENDER_HEADER_EN
        exp0.push_back(8'hA5); exp0.push_back(8'h5A);
        exp1.push_back(8'hA5); exp1.push_back(8'h5A);
`endif
        exp0.push_back(8'h00); exp0.push_back(8'hFF);
        exp0.push_back(8'h55); exp0.push_back(8'h81);
        exp1.push_back(8'h01); exp1.push_back(8'hC3);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx",    32'(tx[0]),    32'd1);
        check("rst_busy",  32'(busy[0]),  32'd0);
        check("rst_done",  32'(done[0]),  32'd0);
        check("rst_rd_en", 32'(rd_en[0]), 32'd0);
        check("rst_addr",  32'(addr0),    32'd0);
        check("rst_addr_lat3", 32'(addr1), 32'd0);
        check("rst_tx_lat3",   32'(tx[1]), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_tx", 32'(tx[0]), 32'd1);

        // Single frame
        dc = done_cnt[0];
        for (int a = 0; a < 4; a++) ac[a] = addr_cnt[a];
        pulse_start(0);
        rx_expect(0, exp0, "f1");
        wait_done(0);
        check("f1_done_latency", 32'(done_at[0] - busy_start[0]), 32'(F0_CYC + HDR_CYC));
        check("f1_done_count",   32'(done_cnt[0] - dc), 32'd1);
        check("f1_busy_at_done", 32'(busy_at_done[0]), 32'd0);
        check("f1_fetch_entry",  32'(first_rd_at[0] - busy_start[0]), 32'(HDR_CYC));
        for (int a = 0; a < 4; a++)
            check($sformatf("f1_addr%0d_cycles", a), 32'(addr_cnt[a] - ac[a]), 32'd2);

        // Start pulse during pixel 2 is ignored
        dc = done_cnt[0];
        for (int a = 0; a < 4; a++) ac[a] = addr_cnt[a];
        pulse_start(0);
        fork
            rx_expect(0, exp0, "f2");
            begin
                t = 0;
                while (!(rd_en[0] === 1'b1 && addr0 === 15'd2) && t < 4000) begin
                    @(negedge clk);
                    t++;
                end
                check("f2_reach_pix2", 32'(addr0), 32'd2);
                @(negedge clk);
                start[0] = 1'b1;
                @(negedge clk);
                start[0] = 1'b0;
            end
        join
        wait_done(0);
        check("f2_done_latency", 32'(done_at[0] - busy_start[0]), 32'(F0_CYC + HDR_CYC));
        check("f2_addr0_cycles", 32'(addr_cnt[0] - ac[0]), 32'd2);
        repeat (50) @(negedge clk);
        check("f2_done_count", 32'(done_cnt[0] - dc), 32'd1);
        check("f2_no_restart", 32'(busy[0]), 32'd0);

        // RAM_LATENCY=3 instance, plus exact bit order of 0x01
        dc = done_cnt[1];
        rc = rd_cnt[1];
        pulse_start(1);
        for (int k = 0; k < HDR_BYTES; k++) begin
            recv_byte(1, b, bits);
            check($sformatf("l3_hdr%0d", k), 32'(b), 32'(exp1[k]));
        end
        recv_byte(1, b, bits);
        check("l3_bits_0x01", 32'(bits), 32'(10'b1000000010));
        recv_byte(1, b, bits);
        check("l3_byte_c3", 32'(b), 32'hC3);
        wait_done(1);
        check("l3_done_latency", 32'(done_at[1] - busy_start[1]), 32'(F1_CYC + HDR_CYC));
        check("l3_rd_en_cycles", 32'(rd_cnt[1] - rc), 32'd8);
        check("l3_fetch_entry",  32'(first_rd_at[1] - busy_start[1]), 32'(HDR_CYC));
        check("l3_done_count",   32'(done_cnt[1] - dc), 32'd1);

        // Asynchronous reset in the middle of data bit 1 of the first byte
        pulse_start(0);
        t = 0;
        while (tx[0] !== 1'b0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (2 * CPB + 2) @(negedge clk);
        check("pre_rst_tx_low", 32'(tx[0]), 32'd0);
        check("pre_rst_busy",   32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx",    32'(tx[0]),    32'd1);
        check("async_rst_busy",  32'(busy[0]),  32'd0);
        check("async_rst_addr",  32'(addr0),    32'd0);
        check("async_rst_rd_en", 32'(rd_en[0]), 32'd0);
        check("async_rst_done",  32'(done[0]),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows  = 0;
        busys = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) lows++;
            if (busy[0] !== 1'b0) busys++;
        end
        check("post_rst_tx_quiet",   32'(lows),  32'd0);
        check("post_rst_busy_quiet", 32'(busys), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
